// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared op-code constants and FSM state type for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;
  localparam logic [3:0] OpMul = 4'b1000;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clock, reset        - clock, async active-high reset (aborts a running multiply)
//   start               - load a/b and begin WIDTH iteration cycles
//   a, b                - operands (sampled when start=1)
//   done                - high during the last iteration cycle; product is final then
//   product             - 2*WIDTH-bit result, valid while done=1
module seq_mul #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_sum;

  // Accumulator including this cycle's partial product; on the last
  // iteration this is the finished product, so the caller can register it
  // on the same edge.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == LastCnt);
  assign product = acc_sum;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready request handshake.
// Single-cycle AND/OR/ADD/SUB/SLT/NOR, multi-cycle MUL via seq_mul.
// Ports:
//   clock, reset            - clock, async active-high reset
//   in_valid, in_ready      - request handshake (no queueing while busy)
//   op, ain, bin            - op code and operands
//   out_valid               - one-cycle pulse when out/flags carry a new result
//   out, carry, overflow,
//   zero, err               - registered result and flags, held between results
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_out;
  logic             res_carry;
  logic             res_overflow;
  logic             res_err;

  // in_ready is forced low while reset is held.
  assign in_ready  = (state_q == StIdle) && !reset;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OpMul);

  seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (mul_start),
    .a      (ain),
    .b      (bin),
    .done   (mul_done),
    .product(mul_product)
  );

  assign sum  = {1'b0, ain} + {1'b0, bin};
  assign diff = {1'b0, ain} - {1'b0, bin};

  // Single-cycle result for the op currently presented.
  always_comb begin
    res_out      = '0;
    res_carry    = 1'b0;
    res_overflow = 1'b0;
    res_err      = 1'b0;
    unique case (op)
      OpAnd: res_out = ain & bin;
      OpOr:  res_out = ain | bin;
      OpNor: res_out = ~(ain | bin);
      OpAdd: begin
        res_out      = sum[WIDTH-1:0];
        res_carry    = sum[WIDTH];
        res_overflow = (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
      end
      OpSub: begin
        res_out      = diff[WIDTH-1:0];
        // diff[WIDTH] is the borrow; carry means no borrow.
        res_carry    = ~diff[WIDTH];
        res_overflow = (ain[WIDTH-1] != bin[WIDTH-1]) && (diff[WIDTH-1] != ain[WIDTH-1]);
      end
      OpSlt: res_out = {{(WIDTH-1){1'b0}}, ($signed(ain) < $signed(bin))};
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpMul) begin
            state_d = StMul;
          end else begin
            out_d       = res_out;
            carry_d     = res_carry;
            overflow_d  = res_overflow;
            zero_d      = (res_out == '0);
            err_d       = res_err;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d     = StIdle;
          out_d       = mul_product[WIDTH-1:0];
          carry_d     = 1'b0;
          overflow_d  = |mul_product[2*WIDTH-1:WIDTH];
          zero_d      = (mul_product[WIDTH-1:0] == '0);
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      out_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..32).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  request present on op/ain/bin.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 op  input  4  operation code (see REQ-011).
REQ-008 ain, bin  input  WIDTH  operands.
REQ-009 out_valid  output  1  one-cycle pulse: out/flags carry a new result.
REQ-010 out  output  WIDTH  result; carry, overflow, zero, err  output  1 each  result flags.

Function
REQ-011 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL; all other codes illegal.
REQ-012 A request SHALL be accepted on a rising edge where in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored (not queued).
REQ-013 States: IDLE (in_ready=1), MUL (in_ready=0); IDLE->MUL on accepted MUL; MUL->IDLE after WIDTH iteration cycles; all other ops stay in IDLE.
REQ-014 Non-MUL ops SHALL have latency 1: out/flags registered on the accepting edge, out_valid high for the following cycle; back-to-back requests SHALL be accepted every cycle.
REQ-015 MUL SHALL be unsigned shift-add, one partial product per cycle; out_valid high for exactly one cycle after the WIDTH-th edge following acceptance.
REQ-016 ADD: out=(ain+bin) mod 2^WIDTH; carry=unsigned carry-out; overflow=two's-complement overflow.
REQ-017 SUB: out=(ain-bin) mod 2^WIDTH; carry=1 iff ain>=bin unsigned (no borrow); overflow=two's-complement overflow.
REQ-018 SLT: out=1 iff signed ain<signed bin, else 0; carry=overflow=0.
REQ-019 AND/OR/NOR: bitwise; carry=overflow=0.
REQ-020 MUL: out=low WIDTH bits of product; overflow=1 iff high WIDTH bits nonzero; carry=0.
REQ-021 zero SHALL equal (out==0) for every result; err=0 for legal ops.
REQ-022 Illegal op SHALL complete with latency 1: out=0, err=1, zero=1, carry=overflow=0.
REQ-023 out and all flags SHALL hold their last value while out_valid=0.
REQ-024 Operands SHALL be captured at acceptance; input changes during MUL SHALL not affect the result.

Reset
REQ-025 While reset=1: state=IDLE, out=0, carry=overflow=zero=err=0, out_valid=0, in_ready=0.
REQ-026 First cycle after reset deasserts, in_ready SHALL be 1.
REQ-027 Reset during MUL SHALL abort it; no out_valid pulse for the aborted request.

Structure
REQ-028 Package seq_alu_pkg SHALL hold op-code constants and the state type (IDLE, MUL).
REQ-029 Multiplier datapath SHALL be a sub-module seq_mul (start, operands, WIDTH-cycle iteration, done pulse, 2*WIDTH product); seq_alu owns FSM, handshake, flags.

Verification (WIDTH=4)
REQ-030 ADD 1000+0001 -> out=1001, carry=0, overflow=0 next cycle; ADD 1111+0001 -> out=0000, carry=1, zero=1; ADD 0111+0001 -> 1000, overflow=1.
REQ-031 SUB 0011-0111 -> out=1100, carry=0, overflow=0; SUB 1000-0001 -> out=0111, overflow=1.
REQ-032 SLT ain=1001, bin=0011 -> out=0001; SLT ain=0011, bin=1001 -> out=0000.
REQ-033 MUL 0011*0101 -> in_ready=0 for 4 cycles, out=1111, overflow=0, single out_valid pulse; MUL 1111*0111 -> out=1001, overflow=1; in_valid held high during MUL not accepted.
REQ-034 Reset asserted asynchronously in 2nd MUL cycle -> outputs 0 immediately, no out_valid; next ADD 0001+0001 -> 0010.
REQ-035 op=0011 -> out=0000, err=1, zero=1; following legal AND 1100&1010 on next cycle -> out=1000, err=0.
